// File: rtl/mem_wb_stage.sv
// Memory stage plus MEM/WB pipeline register: issues the data-memory request,
// stalls upstream until dhit, then registers the writeback value and sticky halt.
module mem_wb_stage #(
    parameter int DW    = 32,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             valid_in,
    input  logic [1:0]       memtoreg_in,
    input  logic             regwrite_in,
    input  logic             dmemREN_in,
    input  logic             dmemWEN_in,
    input  logic             halt_in,
    input  logic [DW-1:0]    rdat2_in,
    input  logic [DW-1:0]    npc_in,
    input  logic [DW-1:0]    aluResult_in,
    input  logic [4:0]       branchDest_in,
    input  logic [DW-1:0]    upper16_in,
    input  logic             dhit,
    input  logic [DW-1:0]    dmemload,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic [DW-1:0]    dmemaddr,
    output logic [DW-1:0]    dmemstore,
    output logic             mem_stall,
    output logic             wb_valid,
    output logic             wb_regwrite,
    output logic [4:0]       wb_wsel,
    output logic [DW-1:0]    wb_wdat,
    output logic             wb_halt,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [1:0]       state
);

    // Handshake: a request (dmemREN/dmemWEN) is held stable while mem_stall=1
    // because upstream is frozen; the access completes on the edge where dhit=1.
    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_WAIT   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t        cur_state;
    state_t        nxt_state;
    logic          active;
    logic          mem_op;
    logic [DW-1:0] wdat_sel;

    assign state     = cur_state;
    assign dmemaddr  = aluResult_in;
    assign dmemstore = rdat2_in;

    // Requests are suppressed while reset is held so nothing escapes mid-reset.
    assign active    = nRST & (cur_state != S_HALTED);
    assign mem_op    = active & valid_in & (dmemREN_in | dmemWEN_in);
    assign dmemWEN   = active & valid_in & dmemWEN_in;
    assign dmemREN   = active & valid_in & dmemREN_in & ~dmemWEN_in;
    assign mem_stall = mem_op & ~dhit;

    always_comb begin
        wdat_sel = aluResult_in;
        case (memtoreg_in)
            2'd0:    wdat_sel = aluResult_in;
            2'd1:    wdat_sel = dmemload;
            2'd2:    wdat_sel = npc_in;
            default: wdat_sel = upper16_in;
        endcase
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            S_RUN: begin
                if (mem_op && !dhit)
                    nxt_state = S_WAIT;
                else if (valid_in && halt_in && !mem_stall)
                    nxt_state = S_HALTED;
            end
            S_WAIT: begin
                if (dhit)
                    nxt_state = S_RUN;
            end
            S_HALTED: nxt_state = S_HALTED;
            default:  nxt_state = S_RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cur_state    <= S_RUN;
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_wsel      <= '0;
            wb_wdat      <= '0;
            wb_halt      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            cur_state <= nxt_state;
            if (cur_state == S_HALTED) begin
                wb_valid    <= 1'b0;
                wb_regwrite <= 1'b0;
                wb_halt     <= 1'b1;
            end else if (mem_stall || !valid_in) begin
                wb_valid    <= 1'b0;
                wb_regwrite <= 1'b0;
            end else begin
                wb_valid    <= 1'b1;
                wb_regwrite <= regwrite_in & (branchDest_in != 5'd0);
                wb_wsel     <= branchDest_in;
                wb_wdat     <= wdat_sel;
                wb_halt     <= wb_halt | halt_in;
            end
            if (mem_stall && !(&stall_cycles))
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: table of single-cycle vectors plus
// hand-written sequences for misses, reset in WAIT, counter saturation and halt.
module tb_mem_wb_stage;

    localparam int DW    = 32;
    localparam int CNT_W = 3;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             valid_in;
    logic [1:0]       memtoreg_in;
    logic             regwrite_in;
    logic             dmemREN_in;
    logic             dmemWEN_in;
    logic             halt_in;
    logic [DW-1:0]    rdat2_in;
    logic [DW-1:0]    npc_in;
    logic [DW-1:0]    aluResult_in;
    logic [4:0]       branchDest_in;
    logic [DW-1:0]    upper16_in;
    logic             dhit;
    logic [DW-1:0]    dmemload;
    logic             dmemREN;
    logic             dmemWEN;
    logic [DW-1:0]    dmemaddr;
    logic [DW-1:0]    dmemstore;
    logic             mem_stall;
    logic             wb_valid;
    logic             wb_regwrite;
    logic [4:0]       wb_wsel;
    logic [DW-1:0]    wb_wdat;
    logic             wb_halt;
    logic [CNT_W-1:0] stall_cycles;
    logic [1:0]       state;

    mem_wb_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .valid_in(valid_in), .memtoreg_in(memtoreg_in),
        .regwrite_in(regwrite_in), .dmemREN_in(dmemREN_in), .dmemWEN_in(dmemWEN_in),
        .halt_in(halt_in), .rdat2_in(rdat2_in), .npc_in(npc_in),
        .aluResult_in(aluResult_in), .branchDest_in(branchDest_in),
        .upper16_in(upper16_in), .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .mem_stall(mem_stall), .wb_valid(wb_valid),
        .wb_regwrite(wb_regwrite), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
        .wb_halt(wb_halt), .stall_cycles(stall_cycles), .state(state)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    typedef struct {
        logic [1:0]    memtoreg;
        logic          regwrite;
        logic          ren;
        logic          wen;
        logic [DW-1:0] rdat2;
        logic [DW-1:0] npc;
        logic [DW-1:0] alu;
        logic [4:0]    dest;
        logic [DW-1:0] upper;
        logic [DW-1:0] load;
        logic          exp_ren;
        logic          exp_wen;
        logic          exp_regwrite;
        logic [DW-1:0] exp_wdat;
    } vec_t;

    vec_t vecs[7];
    int   n_vec = 0;
    int   n_err = 0;

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic idle_inputs();
        valid_in      = 1'b0;
        memtoreg_in   = 2'd0;
        regwrite_in   = 1'b0;
        dmemREN_in    = 1'b0;
        dmemWEN_in    = 1'b0;
        halt_in       = 1'b0;
        rdat2_in      = 32'h5555_0002;
        npc_in        = 32'hAAAA_0004;
        aluResult_in  = 32'h0000_0000;
        branchDest_in = 5'd0;
        upper16_in    = 32'h7777_0000;
        dhit          = 1'b0;
        dmemload      = 32'h0000_0000;
    endtask

    task automatic drive_vec(input vec_t v);
        valid_in      = 1'b1;
        memtoreg_in   = v.memtoreg;
        regwrite_in   = v.regwrite;
        dmemREN_in    = v.ren;
        dmemWEN_in    = v.wen;
        halt_in       = 1'b0;
        rdat2_in      = v.rdat2;
        npc_in        = v.npc;
        aluResult_in  = v.alu;
        branchDest_in = v.dest;
        upper16_in    = v.upper;
        dmemload      = v.load;
        dhit          = 1'b1;
    endtask

    task automatic drive_load(input logic [DW-1:0] addr, input logic [4:0] dest);
        idle_inputs();
        valid_in      = 1'b1;
        memtoreg_in   = 2'd1;
        regwrite_in   = 1'b1;
        dmemREN_in    = 1'b1;
        aluResult_in  = addr;
        branchDest_in = dest;
        dhit          = 1'b0;
    endtask

    function automatic vec_t mk(input logic [1:0] m, input logic rw, input logic ren,
                                input logic wen, input logic [DW-1:0] rdat2,
                                input logic [DW-1:0] npc, input logic [DW-1:0] alu,
                                input logic [4:0] dest, input logic [DW-1:0] upper,
                                input logic [DW-1:0] load, input logic e_ren,
                                input logic e_wen, input logic e_rw,
                                input logic [DW-1:0] e_wdat);
        vec_t v;
        v.memtoreg = m;      v.regwrite = rw;   v.ren = ren;   v.wen = wen;
        v.rdat2 = rdat2;     v.npc = npc;       v.alu = alu;   v.dest = dest;
        v.upper = upper;     v.load = load;
        v.exp_ren = e_ren;   v.exp_wen = e_wen; v.exp_regwrite = e_rw;
        v.exp_wdat = e_wdat;
        return v;
    endfunction

    initial begin
        // ALU op to r5
        vecs[0] = mk(2'd0, 1, 0, 0, 32'h1111_0001, 32'h0000_0008, 32'h0000_0010, 5'd5,
                     32'h2222_0000, 32'h3333_3333, 0, 0, 1, 32'h0000_0010);
        // store with both REN and WEN set: resolves to a write
        vecs[1] = mk(2'd0, 0, 1, 1, 32'hCAFE_0001, 32'h0000_000C, 32'h0000_0200, 5'd7,
                     32'h2222_0000, 32'h3333_3333, 0, 1, 0, 32'h0000_0200);
        // write to $0 is suppressed
        vecs[2] = mk(2'd0, 1, 0, 0, 32'h1111_0001, 32'h0000_0010, 32'h0000_0055, 5'd0,
                     32'h2222_0000, 32'h3333_3333, 0, 0, 0, 32'h0000_0055);
        // link value
        vecs[3] = mk(2'd2, 1, 0, 0, 32'h1111_0001, 32'h0000_0044, 32'h0000_0099, 5'd31,
                     32'h2222_0000, 32'h3333_3333, 0, 0, 1, 32'h0000_0044);
        // LUI value
        vecs[4] = mk(2'd3, 1, 0, 0, 32'h1111_0001, 32'h0000_0048, 32'h0000_0098, 5'd9,
                     32'h1234_0000, 32'h3333_3333, 0, 0, 1, 32'h1234_0000);
        // load that hits immediately
        vecs[5] = mk(2'd1, 1, 1, 0, 32'h1111_0001, 32'h0000_004C, 32'h0000_0300, 5'd3,
                     32'h2222_0000, 32'h0BAD_F00D, 1, 0, 1, 32'h0BAD_F00D);
        // store with regwrite writes the selected ALU value
        vecs[6] = mk(2'd0, 1, 0, 1, 32'h0000_0011, 32'h0000_0050, 32'h0000_0400, 5'd4,
                     32'h2222_0000, 32'h3333_3333, 0, 1, 1, 32'h0000_0400);

        // ---------------- reset ----------------
        idle_inputs();
        nRST       = 1'b0;
        valid_in   = 1'b1;
        dmemWEN_in = 1'b1;
        tick();
        tick();
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_regwrite", wb_regwrite, 0);
        check("rst_wb_wsel", wb_wsel, 0);
        check("rst_wb_wdat", wb_wdat, 0);
        check("rst_wb_halt", wb_halt, 0);
        check("rst_stall_cycles", stall_cycles, 0);
        check("rst_state", state, ST_RUN);
        check("rst_wen_held", dmemWEN, 0);
        nRST = 1'b1;
        dhit = 1'b1;
        #1;
        check("rel_wen", dmemWEN, 1);
        check("rel_stall", mem_stall, 0);
        tick();
        idle_inputs();
        tick();

        // ---------------- table vectors ----------------
        for (int i = 0; i < 7; i++) begin
            drive_vec(vecs[i]);
            #1;
            check($sformatf("v%0d_ren", i), dmemREN, vecs[i].exp_ren);
            check($sformatf("v%0d_wen", i), dmemWEN, vecs[i].exp_wen);
            check($sformatf("v%0d_stall", i), mem_stall, 0);
            check($sformatf("v%0d_addr", i), dmemaddr, vecs[i].alu);
            check($sformatf("v%0d_store", i), dmemstore, vecs[i].rdat2);
            tick();
            check($sformatf("v%0d_wb_valid", i), wb_valid, 1);
            check($sformatf("v%0d_wb_regwrite", i), wb_regwrite, vecs[i].exp_regwrite);
            check($sformatf("v%0d_wb_wsel", i), wb_wsel, vecs[i].dest);
            check($sformatf("v%0d_wb_wdat", i), wb_wdat, vecs[i].exp_wdat);
            check($sformatf("v%0d_state", i), state, ST_RUN);
        end

        // bubble holds wsel/wdat
        idle_inputs();
        tick();
        check("bub_wb_valid", wb_valid, 0);
        check("bub_wb_regwrite", wb_regwrite, 0);
        check("bub_wb_wsel", wb_wsel, 5'd4);
        check("bub_wb_wdat", wb_wdat, 32'h0000_0400);
        check("bub_stall_cycles", stall_cycles, 0);

        // ---------------- load with 3-cycle miss ----------------
        drive_load(32'h0000_0100, 5'd6);
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("miss%0d_stall", c), mem_stall, 1);
            check($sformatf("miss%0d_ren", c), dmemREN, 1);
            check($sformatf("miss%0d_addr", c), dmemaddr, 32'h0000_0100);
            tick();
            check($sformatf("miss%0d_wb_valid", c), wb_valid, 0);
            check($sformatf("miss%0d_state", c), state, ST_WAIT);
        end
        dhit     = 1'b1;
        dmemload = 32'hDEAD_BEEF;
        #1;
        check("miss_hit_stall", mem_stall, 0);
        tick();
        check("miss_wb_valid", wb_valid, 1);
        check("miss_wb_regwrite", wb_regwrite, 1);
        check("miss_wb_wsel", wb_wsel, 5'd6);
        check("miss_wb_wdat", wb_wdat, 32'hDEAD_BEEF);
        check("miss_state", state, ST_RUN);
        check("miss_stall_cycles", stall_cycles, 3);
        idle_inputs();
        tick();

        // ---------------- reset while in WAIT ----------------
        drive_load(32'h0000_0180, 5'd8);
        tick();
        check("rw_state_wait", state, ST_WAIT);
        check("rw_stall_cycles", stall_cycles, 4);
        nRST = 1'b0;
        #1;
        check("rw_ren_in_reset", dmemREN, 0);
        tick();
        check("rw_state", state, ST_RUN);
        check("rw_wb_valid", wb_valid, 0);
        check("rw_wb_wdat", wb_wdat, 0);
        check("rw_wb_wsel", wb_wsel, 0);
        check("rw_stall_cycles_clr", stall_cycles, 0);
        nRST = 1'b1;
        #1;
        check("rw_ren_reissue", dmemREN, 1);
        check("rw_stall_reissue", mem_stall, 1);
        dhit     = 1'b1;
        dmemload = 32'h0000_ABCD;
        tick();
        check("rw_wb_wdat_done", wb_wdat, 32'h0000_ABCD);
        check("rw_wb_wsel_done", wb_wsel, 5'd8);
        idle_inputs();
        tick();

        // ---------------- stall counter saturation ----------------
        drive_load(32'h0000_0200, 5'd2);
        for (int c = 0; c < 9; c++) tick();
        check("sat_stall_cycles", stall_cycles, 3'h7);
        dhit     = 1'b1;
        dmemload = 32'h0000_1234;
        tick();
        check("sat_wb_wdat", wb_wdat, 32'h0000_1234);
        check("sat_hold", stall_cycles, 3'h7);
        idle_inputs();
        tick();

        // ---------------- halt ----------------
        valid_in = 1'b1;
        halt_in  = 1'b1;
        tick();
        check("halt_wb_halt", wb_halt, 1);
        check("halt_state", state, ST_HALTED);
        drive_load(32'h0000_0300, 5'd10);
        #1;
        check("halt_ren", dmemREN, 0);
        check("halt_stall", mem_stall, 0);
        tick();
        check("halt_wb_valid", wb_valid, 0);
        check("halt_wb_regwrite", wb_regwrite, 0);
        check("halt_sticky", wb_halt, 1);
        check("halt_stall_cycles", stall_cycles, 3'h7);
        dhit = 1'b1;
        tick();
        check("halt_sticky2", wb_halt, 1);
        check("halt_state2", state, ST_HALTED);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
